// File: rtl/fifo_ctrl.sv
`default_nettype none
// fifo_ctrl: pointer/flag sequencer for a dual-port FIFO memory (registered write, combinational read).
// Rev 1.0 - registered pop data, occupancy/almost flags, sticky overflow/underflow errors.
module fifo_ctrl #(
  parameter int DATA_WIDTH       = 10,
  parameter int ADDRESS_WIDTH    = 3,
  parameter int ALMOST_FULL_THR  = 6,
  parameter int ALMOST_EMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_err,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     mem_reset_n,
  output logic                     mem_wr_enable,
  output logic                     mem_rd_enable,
  output logic [ADDRESS_WIDTH-1:0] wr_ptr,
  output logic [ADDRESS_WIDTH-1:0] rd_ptr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH   = (ADDRESS_WIDTH+1)'(2**ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] AF_LVL  = (ADDRESS_WIDTH+1)'(ALMOST_FULL_THR);
  localparam logic [ADDRESS_WIDTH:0] AE_LVL  = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_THR);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t state, state_next;

  logic active;
  logic push_ok, pop_ok;
  logic rej_push, rej_pop;

  // Requests are evaluated against the pre-edge flags; a pop frees a slot for a push on full.
  assign active   = (state != INIT);
  assign pop_ok   = active & pop & ~empty;
  assign push_ok  = active & push & (~full | pop_ok);
  assign rej_push = active & push & ~push_ok;
  assign rej_pop  = active & pop & empty;

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign mem_reset_n   = ~reset;
  assign mem_wr_enable = push_ok;
  assign mem_rd_enable = pop_ok;
  assign mem_data_in   = data_in;

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = ACTIVE;
      ACTIVE:  if (rej_push | rej_pop) state_next = ERROR;
      ERROR:   if (clr_err & ~(rej_push | rej_pop)) state_next = ACTIVE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid         <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state <= state_next;
      valid <= pop_ok;
      if (pop_ok) begin
        data_out <= mem_data_out;
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push_ok & ~pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok & ~push_ok) begin
        count <= count - CNT_ONE;
      end
      // A rejection coinciding with clr_err re-arms its own flag.
      if (active) begin
        if (clr_err) begin
          overflow_err  <= rej_push;
          underflow_err <= rej_pop;
        end else begin
          if (rej_push) overflow_err  <= 1'b1;
          if (rej_pop)  underflow_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl with a behavioural memory and reference FIFO model.
// Rev 1.0
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, clr_err, push, pop;
  logic [9:0] data_in, mem_data_out, mem_data_in, data_out;
  logic       mem_reset_n, mem_wr_enable, mem_rd_enable, valid;
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow_err, underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_ctrl dut (
    .clk(clk), .reset(reset), .clr_err(clr_err), .push(push), .pop(pop),
    .data_in(data_in), .mem_data_out(mem_data_out), .mem_reset_n(mem_reset_n),
    .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .mem_data_in(mem_data_in),
    .data_out(data_out), .valid(valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [8];
  always @(posedge clk) if (mem_wr_enable) mem[wr_ptr] <= mem_data_in;
  assign mem_data_out = mem[rd_ptr];

  // Reference model state
  logic [9:0] model_q[$];
  logic [9:0] exp_q[$];
  int m_state = 0;  // 0 INIT, 1 ACTIVE, 2 ERROR
  int m_wp = 0, m_rp = 0;
  bit m_ov = 0, m_un = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int c;
    c = model_q.size();
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(full), 32'(c == 8));
    check({tag, ".empty"}, 32'(empty), 32'(c == 0));
    check({tag, ".afull"}, 32'(almost_full), 32'(c >= 6));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(c <= 2));
    check({tag, ".ovf"}, 32'(overflow_err), 32'(m_ov));
    check({tag, ".unf"}, 32'(underflow_err), 32'(m_un));
    check({tag, ".wptr"}, 32'(wr_ptr), 32'(m_wp));
    check({tag, ".rptr"}, 32'(rd_ptr), 32'(m_rp));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      check("rst.mem_reset_n", 32'(mem_reset_n), 32'd0);
      @(posedge clk); #1;
      model_q.delete(); exp_q.delete();
      m_state = 0; m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0;
      check_status("rst");
      check("rst.valid", 32'(valid), 32'd0);
      check("rst.dout", 32'(data_out), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel.mem_reset_n", 32'(mem_reset_n), 32'd1);
  endtask

  task automatic step(input string tag, input bit p, input bit q, input bit c, input logic [9:0] d);
    bit act, mpush, mpop, rp, ru;
    push = p; pop = q; clr_err = c; data_in = d;
    act   = (m_state != 0);
    mpop  = act && q && (model_q.size() != 0);
    mpush = act && p && ((model_q.size() != 8) || mpop);
    rp    = act && p && !mpush;
    ru    = act && q && (model_q.size() == 0);
    #1;
    check({tag, ".wr_en"}, 32'(mem_wr_enable), 32'(mpush));
    check({tag, ".rd_en"}, 32'(mem_rd_enable), 32'(mpop));
    check({tag, ".mem_din"}, 32'(mem_data_in), 32'(d));
    if (mpop) exp_q.push_back(model_q.pop_front());
    if (mpush) model_q.push_back(d);
    if (mpush) m_wp = (m_wp + 1) % 8;
    if (mpop)  m_rp = (m_rp + 1) % 8;
    if (act) begin
      if (c) begin m_ov = rp; m_un = ru; end
      else begin m_ov = m_ov | rp; m_un = m_un | ru; end
    end
    case (m_state)
      0: m_state = 1;
      1: if (rp || ru) m_state = 2;
      default: if (c && !(rp || ru)) m_state = 1;
    endcase
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(valid), 32'(mpop));
    if (valid) begin
      if (exp_q.size() == 0) check({tag, ".unexpected_data"}, 32'(data_out), 32'hFFFF_FFFF);
      else check({tag, ".dout"}, 32'(data_out), 32'(exp_q.pop_front()));
    end
    check_status(tag);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    do_reset(2);
    step("init_push", 1, 0, 0, 10'h155);
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 10'(i));
    step("ovf_push", 1, 0, 0, 10'h0AA);
    step("ovf_hold", 0, 0, 0, 10'h000);
    step("clr_ovf", 0, 0, 1, 10'h000);
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 0, 10'h000);
    step("unf_pop", 0, 1, 0, 10'h000);
    step("clr_rej", 0, 1, 1, 10'h000);
    step("clr_unf", 0, 0, 1, 10'h000);
    for (int i = 0; i < 8; i++) step("refill", 1, 0, 0, 10'(10'h10 + i));
    step("full_pp", 1, 1, 0, 10'h3FF);
    for (int i = 0; i < 8; i++) step("drain2", 0, 1, 0, 10'h000);
    step("empty_pp", 1, 1, 0, 10'h2A5);
    step("clr2", 0, 0, 1, 10'h000);
    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 10'($urandom));
    while (model_q.size() > 5) step("trim", 0, 1, 0, 10'h000);
    while (model_q.size() < 5) step("top5", 1, 0, 0, 10'(10'h100 + model_q.size()));
    check("pre_rst.count", 32'(count), 32'd5);
    do_reset(1);
    step("post_rst", 0, 1, 0, 10'h000);
    step("post_rst2", 1, 0, 0, 10'h0F0);
    step("post_rst3", 0, 1, 0, 10'h000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
